wb_decompressor: RTL and testbench
==================================

Name: wb_decompressor

Overview:
- Slave-side endpoint of the compressed wishbone link (cw bus); sits downstream of the wb_compressor master.
- Receives a header, a low address word and write data over the 16-bit cw bus.
- Replays each transfer as single or burst wishbone master cycles on the local bus.
- Returns read data and per-beat ack/err pulses to the compressor.

Parameters:
- RW, 16, data word width.
- WB_ADDR_W, 24, wishbone word-address width.
- TIMEOUT_CYC, 255, beat watchdog limit; used only with CW_DECOMP_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- cw_io_i  in  RW  word from compressor
- cw_io_o  out  RW  read data to compressor
- cw_req  in  1  header/next-write-word strobe
- cw_dir  in  1  bus direction: 0 = compressor drives, 1 = decompressor drives
- cw_ack  out  1  beat/header ack pulse
- cw_err  out  1  beat error pulse
- wb_cyc, wb_stb, wb_we  out  1  wishbone master controls
- wb_adr  out  WB_ADDR_W  wishbone address
- wb_sel  out  2  byte selects
- wb_o_dat  out  RW  write data
- wb_i_dat  in  RW  read data
- wb_ack, wb_err  in  1  wishbone response

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk. All outputs are 0 and the state is IDLE. Reset mid-transfer drops wb_cyc/wb_stb next cycle and discards the transfer. cw_req is ignored while i_rst=1.
- Header word 0 layout: [15:8]=adr[23:16], [7:4]=cyc_type, [3]=we, [2:1]=sel, [0]=valid.
- cyc_type encoding: 0000 = 1 beat, 0001 = 8 beats, 0010 = 4 beats; any other value is invalid.
- Link timing (T0 = cycle with cw_req=1 in IDLE and cw_io_i[0]=1):
  - T0: latch header. cw_req with valid=0 is ignored.
  - T1 (HDR_ADR): latch cw_io_i as adr[15:0].
  - T2 (HDR_ACK): cw_ack=1 for exactly one cycle.
  - Write: at T3 (W_CAP), capture cw_io_i as beat-0 data.
  - Read: go to R_BUS at T3.
- Beat count rule: beat_cnt is 3 bits; last beat = 0/7/3 for 1/8/4-beat types.
- Address rule: beat address = latched address + beat_cnt, modulo 2^24. sel and we are constant for the whole transfer.
- Wishbone side:
  - wb_cyc rises at T3 and stays high until the final beat response, then falls.
  - wb_stb is high only while a beat is outstanding; it drops the cycle after wb_ack or wb_err.
  - If wb_ack and wb_err arrive together, err wins.
- Write beat flow:
  - W_BUS: drive wb_o_dat = captured word, wait for wb response.
  - W_RSP: pulse cw_ack (or cw_err on wb_err) for one cycle.
  - Not last beat → W_WREQ: wait for cw_req=1, capture cw_io_i that same cycle, then → W_BUS.
  - Last beat → DONE.
- Read beat flow:
  - R_BUS: wait for wb response; register wb_i_dat into cw_io_o.
  - R_RSP: pulse cw_ack/cw_err for one cycle. cw_io_o holds its value until the next beat's response.
  - Not last beat → R_GAP for one idle cycle, then → R_BUS. Ack pulses are therefore never back-to-back.
  - Last beat → DONE.
- DONE: one cycle with all wb signals low, then → IDLE. A new header is accepted from the following cycle.
- Pulse rule: cw_ack and cw_err are never high together and never high longer than one cycle.
- Invalid cyc_type: run as a 1-beat transfer with no wishbone access. Header ack is normal; the single data beat returns cw_err.
- cw_req during any non-IDLE state other than W_WREQ is ignored.
- cw_dir is informational only; cw_io_o is driven regardless and the pad tristate uses cw_dir.

Optional Feature:
- Macro: CW_DECOMP_TIMEOUT_EN.
- With it: a counter runs while wb_stb=1. On reaching TIMEOUT_CYC with no response, the beat is abandoned: wb_stb drops, cw_err pulses, and the burst continues with the next beat. Read data for an abandoned beat is 0.
- Without it: the block waits for a wishbone response indefinitely.

Decomposition:
- Shared package holds:
  - RW and WB_ADDR_W
  - cyc_type encodings
  - header bit-field positions
  - burst-length decode function
  - state encodings, shared with wb_compressor's header build
- One natural sub-module, cw_beat_watchdog: counter with clear/enable/expire, instantiated only under CW_DECOMP_TIMEOUT_EN.

Test Plan:
- Single write: header 0x12_0_C_B? → hdr0 = 0x120D (type 0, we=1, sel=2'b10, valid), adr word 0x3456, data 0xBEEF → one wb write at adr 0x123456, wb_sel=2'b10, wb_o_dat=0xBEEF. Expect cw_ack at T2 and after wb_ack; wb_cyc low in DONE.
- 4-beat read at 0xFFFFFE, hdr0 = 0xFF27 → wb reads at 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001. cw_io_o matches wb_i_dat on each of 4 ack pulses, with ≥1 idle cycle between pulses.
- 8-beat write, delay cw_req 5 cycles between beats → 8 wb writes with consecutive addresses. wb_cyc stays high throughout; exactly 9 cw_ack pulses (header + 8).
- wb_err on beat 2 of a 4-beat read → cw_err pulse on beat 2 only. Beats 3–4 still issued; cw_ack on the others.
- Invalid cyc_type 0111 → header ack, then one cw_err, no wb_cyc; i_rst asserted during W_BUS → next cycle wb_cyc=0, state IDLE, cw_ack=0.
- With CW_DECOMP_TIMEOUT_EN and TIMEOUT_CYC=4, no wb_ack → wb_stb drops after 4 cycles and cw_err pulses.

Source files
------------

// File: rtl/wb_decompressor_pkg.sv
// Shared cw-link constants: header layout, cycle types, FSM states.
package wb_decompressor_pkg;

  localparam int CW_RW     = 16;
  localparam int CW_ADDR_W = 24;

  localparam logic [3:0] CYC_SINGLE = 4'b0000;
  localparam logic [3:0] CYC_BURST8 = 4'b0001;
  localparam logic [3:0] CYC_BURST4 = 4'b0010;

  localparam int HDR_ADR_HI  = 15;
  localparam int HDR_ADR_LO  = 8;
  localparam int HDR_TYPE_HI = 7;
  localparam int HDR_TYPE_LO = 4;
  localparam int HDR_WE      = 3;
  localparam int HDR_SEL_HI  = 2;
  localparam int HDR_SEL_LO  = 1;
  localparam int HDR_VALID   = 0;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HDR_ADR = 4'd1,
    HDR_ACK = 4'd2,
    W_CAP   = 4'd3,
    W_BUS   = 4'd4,
    W_RSP   = 4'd5,
    W_WREQ  = 4'd6,
    R_BUS   = 4'd7,
    R_RSP   = 4'd8,
    R_GAP   = 4'd9,
    DONE    = 4'd10
  } cw_state_e;

  function automatic logic cyc_ok(
    input logic [3:0] t
  );
    return (t == CYC_SINGLE) ||
           (t == CYC_BURST8) ||
           (t == CYC_BURST4);
  endfunction

  // index of the final beat; unknown types run as one beat
  function automatic logic [2:0] cyc_last(
    input logic [3:0] t
  );
    logic [2:0] l;
    l = 3'd0;
    unique case (1'b1)
      (t == CYC_BURST8): l = 3'd7;
      (t == CYC_BURST4): l = 3'd3;
      default:           l = 3'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/wb_decompressor_cw_beat_watchdog.sv
// Beat watchdog: counts enabled cycles, expires at LIMIT.
module cw_beat_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_decompressor.sv
// cw-link slave: replays compressed transfers as wishbone cycles.
// Optional beat timeout with CW_DECOMP_TIMEOUT_EN.
module wb_decompressor
  import wb_decompressor_pkg::*;
#(
  parameter int RW          = CW_RW,
  parameter int WB_ADDR_W   = CW_ADDR_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [RW-1:0]        cw_io_i,
  output logic [RW-1:0]        cw_io_o,
  input  logic                 cw_req,
  input  logic                 cw_dir,
  output logic                 cw_ack,
  output logic                 cw_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [WB_ADDR_W-1:0] wb_adr,
  output logic [1:0]           wb_sel,
  output logic [RW-1:0]        wb_o_dat,
  input  logic [RW-1:0]        wb_i_dat,
  input  logic                 wb_ack,
  input  logic                 wb_err
);
  localparam int LO_W = 16;

  cw_state_e st, nxt;

  logic [WB_ADDR_W-1:0] adr_q;
  logic [2:0]           beat_q;
  logic [2:0]           last_q;
  logic [1:0]           sel_q;
  logic [RW-1:0]        wdat_q;
  logic [RW-1:0]        rdat_q;
  logic                 we_q;
  logic                 bad_q;
  logic                 err_q;

  logic hdr_hit;
  logic is_last;
  logic tmo;
  logic rsp;
  logic rsp_err;
  logic cyc_on;

  assign hdr_hit = cw_req && cw_io_i[HDR_VALID];
  assign is_last = (beat_q == last_q);

  // an invalid type completes its beat at once, as an error
  assign rsp     = bad_q || wb_ack || wb_err || tmo;
  assign rsp_err = bad_q || wb_err || (tmo && !wb_ack);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (hdr_hit) nxt = HDR_ADR;
      HDR_ADR: nxt = HDR_ACK;
      HDR_ACK: nxt = we_q ? W_CAP : R_BUS;
      W_CAP:   nxt = W_BUS;
      W_BUS:   if (rsp) nxt = W_RSP;
      W_RSP:   nxt = is_last ? DONE : W_WREQ;
      W_WREQ:  if (cw_req) nxt = W_BUS;
      R_BUS:   if (rsp) nxt = R_RSP;
      R_RSP:   nxt = is_last ? DONE : R_GAP;
      R_GAP:   nxt = R_BUS;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q  <= '0;
      beat_q <= '0;
      last_q <= '0;
      sel_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      we_q   <= 1'b0;
      bad_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (hdr_hit) begin
          adr_q[WB_ADDR_W-1:LO_W] <=
            cw_io_i[HDR_ADR_HI:HDR_ADR_LO];
          we_q   <= cw_io_i[HDR_WE];
          sel_q  <= cw_io_i[HDR_SEL_HI:HDR_SEL_LO];
          bad_q  <= !cyc_ok(
            cw_io_i[HDR_TYPE_HI:HDR_TYPE_LO]);
          last_q <= cyc_last(
            cw_io_i[HDR_TYPE_HI:HDR_TYPE_LO]);
          beat_q <= '0;
          err_q  <= 1'b0;
        end
        HDR_ADR: adr_q[LO_W-1:0] <= cw_io_i[LO_W-1:0];
        W_CAP:   wdat_q <= cw_io_i;
        W_WREQ:  if (cw_req) wdat_q <= cw_io_i;
        W_BUS:   if (rsp) err_q <= rsp_err;
        R_BUS: if (rsp) begin
          err_q  <= rsp_err;
          // abandoned or skipped beats read back as zero
          rdat_q <= (wb_ack || wb_err) ? wb_i_dat : '0;
        end
        W_RSP, R_RSP: if (!is_last) beat_q <= beat_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cyc_on = 1'b0;
    wb_stb = 1'b0;
    cw_ack = 1'b0;
    cw_err = 1'b0;
    unique case (st)
      W_CAP, W_WREQ, R_GAP: cyc_on = 1'b1;
      W_BUS, R_BUS: begin
        cyc_on = 1'b1;
        wb_stb = !bad_q;
      end
      W_RSP, R_RSP: begin
        cyc_on = !is_last;
        cw_ack = !err_q;
        cw_err = err_q;
      end
      HDR_ACK: cw_ack = 1'b1;
      default: ;
    endcase
  end

  assign wb_cyc   = cyc_on && !bad_q;
  assign wb_we    = wb_cyc && we_q;
  assign wb_sel   = wb_cyc ? sel_q : '0;
  assign wb_adr   = wb_cyc ? adr_q + WB_ADDR_W'(beat_q) : '0;
  assign wb_o_dat = wb_we ? wdat_q : '0;
  assign cw_io_o  = rdat_q;

`ifdef CW_DECOMP_TIMEOUT_EN
  cw_beat_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr   (!wb_stb),
    .en    (wb_stb),
    .expire(tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // pad direction is handled outside this block
  logic unused_ok;
  assign unused_ok = ^{cw_dir, 32'(TIMEOUT_CYC)};

endmodule

// File: tb/tb_wb_decompressor.sv
// Bench for wb_decompressor: cw-side driver, wishbone slave,
// transfer-level expectation queues.
module tb_wb_decompressor;

`ifdef CW_DECOMP_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] cw_io_i;
  logic [15:0] cw_io_o;
  logic        cw_req;
  logic        cw_dir;
  logic        cw_ack;
  logic        cw_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [23:0] wb_adr;
  logic [1:0]  wb_sel;
  logic [15:0] wb_o_dat;
  logic [15:0] wb_i_dat;
  logic        wb_ack;
  logic        wb_err;

  wb_decompressor #(
    .RW(16),
    .WB_ADDR_W(24),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .cw_io_i (cw_io_i),
    .cw_io_o (cw_io_o),
    .cw_req  (cw_req),
    .cw_dir  (cw_dir),
    .cw_ack  (cw_ack),
    .cw_err  (cw_err),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_we   (wb_we),
    .wb_adr  (wb_adr),
    .wb_sel  (wb_sel),
    .wb_o_dat(wb_o_dat),
    .wb_i_dat(wb_i_dat),
    .wb_ack  (wb_ack),
    .wb_err  (wb_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dat;
  } beat_t;

  typedef struct {
    bit          err;
    bit          cd;
    logic [15:0] dat;
    bit          cyc;
  } pulse_t;

  beat_t       bq[$];
  pulse_t      pq[$];
  logic [23:0] adr_log[$];
  logic [15:0] dat_log[$];

  int tests = 0;
  int fails = 0;
  int n_ack = 0;
  int n_err = 0;
  int slave_wait = 0;
  int slave_idx = 0;
  int stb_cnt = 0;
  int stb_run = 0;
  int err_beat = -1;
  bit both = 0;
  bit hang = 0;
  bit saw_cyc = 0;
  bit prev_p = 0;
  beat_t  b;
  pulse_t p;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nbeats(input logic [3:0] t);
    case (t)
      4'h0:    return 1;
      4'h1:    return 8;
      4'h2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] rpat(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'h5A};
  endfunction

  // compare pulses, act as wishbone slave, check each beat
  always @(negedge i_clk) begin
    if (wb_cyc) saw_cyc = 1;
    if (cw_ack) n_ack++;
    if (cw_err) n_err++;
    if (cw_ack || cw_err) begin
      chk("pulse_excl", {cw_ack, cw_err} == 2'b11, 0);
      chk("pulse_gap", prev_p, 0);
      if (pq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pulse_unexpected: ack=%0b err=%0b, none expected",
                 cw_ack, cw_err);
      end else begin
        p = pq.pop_front();
        chk("pulse_kind", cw_err, p.err);
        chk("pulse_cyc", wb_cyc, p.cyc);
        if (p.cd) chk("rd_data", cw_io_o, p.dat);
      end
    end
    prev_p = cw_ack || cw_err;

    wb_ack = 0;
    wb_err = 0;
    wb_i_dat = '0;
    if (wb_stb) stb_run++;
    if (wb_stb && !i_rst && !hang) begin
      if (stb_cnt >= slave_wait) begin
        stb_cnt = 0;
        if (slave_idx == err_beat) begin
          wb_err = 1;
          wb_ack = both;
        end else begin
          wb_ack = 1;
        end
        wb_i_dat = rpat(wb_adr);
        adr_log.push_back(wb_adr);
        dat_log.push_back(wb_o_dat);
        if (bq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: beat at %0h, none expected",
                   wb_adr);
        end else begin
          b = bq.pop_front();
          chk("wb_beat",
              {wb_adr, wb_we, wb_sel, wb_we ? wb_o_dat : 16'h0},
              {b.adr, b.we, b.sel, b.we ? b.dat : 16'h0});
        end
        slave_idx++;
      end else begin
        stb_cnt++;
      end
    end
  end

  task automatic wait_pulse();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      if (cw_ack || cw_err) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL pulse_timeout: no cw_ack/cw_err in 300 cycles");
    end
  endtask

  // T0..T2 of the link; returns at the negedge of T2
  task automatic start_hdr(input logic [15:0] h0,
                           input logic [15:0] a,
                           input logic [15:0] d0);
    @(posedge i_clk); #1;
    cw_req = 1;
    cw_io_i = h0;
    @(posedge i_clk); #1;
    cw_req = 0;
    cw_io_i = a;
    @(posedge i_clk); #1;
    cw_io_i = d0;
    @(negedge i_clk);
    chk("hdr_ack_T2", {cw_ack, cw_err}, 2'b10);
  endtask

  task automatic xfer(input logic [15:0] h0,
                      input logic [15:0] a,
                      input logic [15:0] d0,
                      input int gap);
    int n;
    bit bad;
    bit we;
    bit e;
    logic [23:0] base;
    logic [23:0] ba;
    n = nbeats(h0[7:4]);
    bad = (n == 0);
    if (bad) n = 1;
    we = h0[3];
    base = {h0[15:8], a};
    slave_idx = 0;
    stb_cnt = 0;
    adr_log.delete();
    dat_log.delete();
    pq.push_back('{err: 0, cd: 0, dat: 16'h0, cyc: 0});
    for (int i = 0; i < n; i++) begin
      ba = base + 24'(i);
      if (bad) begin
        pq.push_back('{err: 1, cd: 0, dat: 16'h0, cyc: 0});
      end else if (hang) begin
        pq.push_back('{err: 1, cd: !we, dat: 16'h0, cyc: 0});
      end else begin
        bq.push_back('{adr: ba, we: we, sel: h0[2:1],
                       dat: d0 + 16'(i) * 16'h0101});
        e = (i == err_beat);
        pq.push_back('{err: e, cd: !we && !e, dat: rpat(ba),
                       cyc: (i != n - 1)});
      end
    end
    start_hdr(h0, a, d0);
    for (int i = 0; i < n; i++) begin
      if (we && i > 0) begin
        repeat (gap) @(posedge i_clk);
        if (gap > 0) begin
          @(negedge i_clk);
          chk("cyc_in_gap", wb_cyc, 1);
        end
        @(posedge i_clk); #1;
        cw_req = 1;
        cw_io_i = d0 + 16'(i) * 16'h0101;
        @(posedge i_clk); #1;
        cw_req = 0;
      end
      wait_pulse();
    end
    @(negedge i_clk);
    chk("done_idle", {wb_cyc, wb_stb, cw_ack, cw_err}, 0);
    chk("queues_empty", pq.size() + bq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    i_rst = 1;
    cw_dir = 0;
    cw_req = 1;
    cw_io_i = 16'h120D;
    wb_ack = 0;
    wb_err = 0;
    wb_i_dat = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_out",
        {cw_ack, cw_err, wb_cyc, wb_stb, wb_we, wb_sel,
         wb_adr, wb_o_dat, cw_io_o}, 0);
    i_rst = 0;
    cw_req = 0;
    repeat (4) @(negedge i_clk);
    chk("req_in_reset_ignored", n_ack + n_err, 0);

    // single write
    xfer(16'h120D, 16'h3456, 16'hBEEF, 0);
    chk("lit_w1_count", adr_log.size(), 1);
    chk("lit_w1_adr", adr_log[0], 24'h123456);
    chk("lit_w1_dat", dat_log[0], 16'hBEEF);
    chk("lit_w1_acks", n_ack, 2);

    // 4-beat read wrapping the address space
    xfer(16'hFF27, 16'hFFFE, 16'h0, 0);
    chk("lit_r4_a0", adr_log[0], 24'hFFFFFE);
    chk("lit_r4_a1", adr_log[1], 24'hFFFFFF);
    chk("lit_r4_a2", adr_log[2], 24'h000000);
    chk("lit_r4_a3", adr_log[3], 24'h000001);

    // 8-beat write, cw_req delayed between beats
    a0 = n_ack;
    xfer(16'hAB1B, 16'hFFFC, 16'h1000, 5);
    chk("w8_ack_count", n_ack - a0, 9);
    chk("lit_w8_a7", adr_log[7], 24'hAC0003);

    // wb_err on second beat of a 4-beat read
    err_beat = 1;
    a0 = n_err;
    xfer(16'h4027, 16'h0100, 16'h0, 0);
    chk("r4_err_count", n_err - a0, 1);
    chk("r4_err_beats", adr_log.size(), 4);

    // ack and err together: err wins
    err_beat = 0;
    both = 1;
    xfer(16'h300F, 16'h0200, 16'h5555, 0);
    both = 0;
    err_beat = -1;

    // invalid cycle types, write and read
    saw_cyc = 0;
    a0 = n_err;
    xfer(16'h007F, 16'h0300, 16'h7777, 0);
    xfer(16'h0035, 16'h0400, 16'h0, 0);
    chk("bad_no_cyc", saw_cyc, 0);
    chk("bad_err_count", n_err - a0, 2);

    // header with valid=0 is ignored
    a0 = n_ack + n_err;
    @(posedge i_clk); #1;
    cw_req = 1;
    cw_io_i = 16'h1200;
    @(posedge i_clk); #1;
    cw_req = 0;
    repeat (4) @(negedge i_clk);
    chk("invalid_hdr_ignored", n_ack + n_err - a0, 0);
    chk("invalid_hdr_no_cyc", saw_cyc, 0);

    // reset while a write beat waits on the bus
    slave_wait = 1000;
    stb_cnt = 0;
    pq.push_back('{err: 0, cd: 0, dat: 16'h0, cyc: 0});
    start_hdr(16'h120D, 16'h0008, 16'hCAFE);
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (wb_stb) break;
    end
    chk("rst_stb_seen", wb_stb, 1);
    i_rst = 1;
    @(negedge i_clk);
    chk("rst_mid", {wb_cyc, wb_stb, cw_ack, cw_err}, 0);
    i_rst = 0;
    slave_wait = 0;
    pq.delete();
    bq.delete();

    // block is back in IDLE: a single read goes through
    xfer(16'h5501, 16'h0010, 16'h0, 0);
    chk("lit_after_rst_adr", adr_log[0], 24'h550010);

`ifdef CW_DECOMP_TIMEOUT_EN
    // no wishbone response: watchdog abandons the beat
    hang = 1;
    stb_run = 0;
    a0 = n_err;
    xfer(16'h4401, 16'h0002, 16'h0, 0);
    hang = 0;
    chk("tmo_stb_cycles", stb_run, 4);
    chk("tmo_err", n_err - a0, 1);
`endif

    repeat (3) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
